risc_imem_loader: RTL and testbench



---
 rtl/risc_pkg.sv | 18 +
 rtl/risc_imem_ram.sv | 35 +++
 rtl/risc_imem_loader.sv | 137 +++++++++++++
 tb/tb_risc_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC instruction memory and its loader.
package risc_pkg;

  // Default instruction and address widths of the core.
  localparam int IW_DEFAULT = 13;
  localparam int AW_DEFAULT = 5;

  // NOP encoding, also recognised by the decoder.
  localparam logic [IW_DEFAULT-1:0] NOP_ENC = '0;

  // Loader sequencer states.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/risc_imem_ram.sv
// Instruction storage: one synchronous write port and one read port.
// The read path is combinational so the loader can place the single
// output register (with its reset value) at the top level.
module risc_imem_ram #(
  parameter int IW = 13,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  // The array has no reset; its content is defined by the clear sequence.
  logic [IW-1:0] mem_q [2**AW];

  // Write port: one word per enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: data presented only while a read is requested.
  always_comb begin
    rdata = '0;
    if (re) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/risc_imem_loader.sv
// Instruction memory with run-time program load, hardware clear and a
// registered, handshaked fetch port.
module risc_imem_loader
  import risc_pkg::*;
#(
  parameter int            IW  = IW_DEFAULT,
  parameter int            AW  = AW_DEFAULT,
  parameter logic [IW-1:0] NOP = IW'(NOP_ENC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_done,
  input  logic          fetch_req,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          pending_q, pending_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [IW-1:0] ram_wdata;
  logic          ram_re;
  logic [IW-1:0] ram_rdata;

  risc_imem_ram #(
    .IW(IW),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(pc),
    .rdata(ram_rdata)
  );

  // State, write pointer, pending flag and output registers; a reset
  // drops any partial load and restarts the clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      wptr_q    <= '0;
      pending_q <= 1'b0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Sequencer: CLEAR sweeps NOP over every word, LOAD streams words into
  // consecutive addresses, RUN serves fetches and accepts new loads.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    ram_wdata = load_data;
    ram_re    = 1'b0;

    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = NOP;
        wptr_d    = wptr_q + AW'(1);
        // During a load-initiated clear the flag is already set, so this
        // only has an effect in the clear that follows reset.
        if (load_start) begin
          pending_d = 1'b1;
        end
        if (wptr_q == LAST_ADDR) begin
          wptr_d  = '0;
          state_d = (pending_q || load_start) ? LOAD : RUN;
        end
      end

      LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (load_last || (wptr_q == LAST_ADDR)) begin
            state_d   = RUN;
            pending_d = 1'b0;
            wptr_d    = '0;
            done_d    = 1'b1;
          end
        end
      end

      RUN: begin
        ram_re = fetch_req;
        if (load_start) begin
          pending_d = 1'b1;
          state_d   = CLEAR;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase

    valid_d = ram_re;
    instr_d = ram_re ? ram_rdata : instr_q;
  end

  assign load_ready  = (state_q == LOAD);
  assign busy        = (state_q != RUN);
  assign load_done   = done_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_risc_imem_loader.sv
// Directed, self-checking bench for the instruction memory loader.
module tb_risc_imem_loader;

  localparam int IW = 13;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          load_done;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          busy;

  int            checks = 0;
  int            fails = 0;
  logic [IW-1:0] lastInstr = '0;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic [IW-1:0] expInstr;
    logic          expValid;
  } vec_t;

  vec_t vecs[12];

  risc_imem_loader #(
    .IW(IW),
    .AW(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .busy       (busy)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Hard stop in case the sequence gets stuck.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [AW-1:0] addr);
    fetch_req = req;
    pc        = addr;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic fetchCheck(input string name, input logic [AW-1:0] addr, input logic [IW-1:0] exp);
    applyStimulus(1'b1, addr);
    checkOutput({name, " data"}, 32'(instruction), 32'(exp));
    checkOutput({name, " valid"}, 32'(instr_valid), 32'd1);
    lastInstr = exp;
  endtask

  task automatic waitClear(input string name, input logic toLoad, input logic fetchDuring,
                           input logic [AW-1:0] addr);
    int   n;
    logic reached;
    n = 0;
    reached = 1'b0;
    while (!reached && n < 64) begin
      fetch_req = fetchDuring;
      pc        = addr;
      tick();
      n++;
      checkOutput({name, " valid during clear"}, 32'(instr_valid), 32'd0);
      checkOutput({name, " instr held"}, 32'(instruction), 32'(lastInstr));
      checkOutput({name, " no done"}, 32'(load_done), 32'd0);
      reached = toLoad ? load_ready : !busy;
    end
    fetch_req = 1'b0;
    checkOutput({name, " clear cycles"}, 32'(n), 32'd32);
  endtask

  task automatic startLoad(input string name);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
  endtask

  task automatic sendWord(input string name, input logic [IW-1:0] data, input logic last);
    checkOutput({name, " ready"}, 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    checkOutput("reset instruction", 32'(instruction), 32'd0);
    checkOutput("reset instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset load_done", 32'(load_done), 32'd0);
    checkOutput("reset load_ready", 32'(load_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset-initiated clear, then every word reads NOP back-to-back
    waitClear("boot", 1'b0, 1'b0, '0);
    checkOutput("boot busy", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      fetchCheck("boot nop", AW'(i), 13'h0000);
    end

    // Short load terminated by load_last
    startLoad("short");
    waitClear("short", 1'b1, 1'b0, '0);
    sendWord("short w0", 13'h1c00, 1'b0);
    checkOutput("short no done w0", 32'(load_done), 32'd0);
    sendWord("short w1", 13'h1c11, 1'b0);
    sendWord("short w2", 13'h0208, 1'b1);
    checkOutput("short done", 32'(load_done), 32'd1);
    checkOutput("short busy", 32'(busy), 32'd0);
    checkOutput("short ready off", 32'(load_ready), 32'd0);
    fetchCheck("short pc2", 5'd2, 13'h0208);
    checkOutput("short done pulse", 32'(load_done), 32'd0);
    fetchCheck("short pc3", 5'd3, 13'h0000);
    fetchCheck("short pc0", 5'd0, 13'h1c00);
    fetchCheck("short pc1", 5'd1, 13'h1c11);

    // load_start on the same edge as a fetch: fetch still serviced
    load_start = 1'b1;
    fetch_req  = 1'b1;
    pc         = 5'd1;
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    checkOutput("start+fetch data", 32'(instruction), 32'h1c11);
    checkOutput("start+fetch valid", 32'(instr_valid), 32'd1);
    checkOutput("start+fetch busy", 32'(busy), 32'd1);
    lastInstr = 13'h1c11;
    waitClear("start+fetch", 1'b1, 1'b1, 5'd2);

    // Full load without load_last: implicit end at the last address
    for (int i = 0; i < 32; i++) begin
      sendWord("full", IW'(i), 1'b0);
      if (i == 30) begin
        checkOutput("full no early done", 32'(load_done), 32'd0);
        checkOutput("full still loading", 32'(load_ready), 32'd1);
      end
    end
    checkOutput("full done", 32'(load_done), 32'd1);
    checkOutput("full busy", 32'(busy), 32'd0);

    vecs[0]  = '{1'b1, 5'd31, 13'h001f, 1'b1};
    vecs[1]  = '{1'b1, 5'd0,  13'h0000, 1'b1};
    vecs[2]  = '{1'b1, 5'd5,  13'h0005, 1'b1};
    vecs[3]  = '{1'b0, 5'd9,  13'h0005, 1'b0};
    vecs[4]  = '{1'b1, 5'd17, 13'h0011, 1'b1};
    vecs[5]  = '{1'b1, 5'd18, 13'h0012, 1'b1};
    vecs[6]  = '{1'b1, 5'd19, 13'h0013, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  13'h0013, 1'b0};
    vecs[8]  = '{1'b0, 5'd3,  13'h0013, 1'b0};
    vecs[9]  = '{1'b1, 5'd10, 13'h000a, 1'b1};
    vecs[10] = '{1'b1, 5'd30, 13'h001e, 1'b1};
    vecs[11] = '{1'b1, 5'd1,  13'h0001, 1'b1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req, vecs[i].addr);
      checkOutput($sformatf("vec%0d data", i), 32'(instruction), 32'(vecs[i].expInstr));
      checkOutput($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
    end
    checkOutput("vec done low", 32'(load_done), 32'd0);
    lastInstr = 13'h0001;

    // Gapped load: idle cycles carry junk and a fetch that must be ignored
    startLoad("gap");
    waitClear("gap", 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b0;
      load_data  = 13'h1fff;
      fetch_req  = 1'b1;
      pc         = AW'(i);
      tick();
      fetch_req  = 1'b0;
      checkOutput("gap fetch ignored valid", 32'(instr_valid), 32'd0);
      checkOutput("gap fetch ignored data", 32'(instruction), 32'(lastInstr));
      sendWord("gap word", IW'(13'h0a00 + i), (i == 7));
    end
    checkOutput("gap done", 32'(load_done), 32'd1);
    checkOutput("gap busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      fetchCheck("gap read", AW'(i), IW'(13'h0a00 + i));
    end
    fetchCheck("gap pc8 cleared", 5'd8, 13'h0000);
    fetchCheck("gap pc31 cleared", 5'd31, 13'h0000);

    // Reset in the middle of a load
    startLoad("abort");
    waitClear("abort", 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      sendWord("abort word", IW'(13'h1500 + i), 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort reset instruction", 32'(instruction), 32'd0);
    checkOutput("abort reset instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("abort reset load_done", 32'(load_done), 32'd0);
    checkOutput("abort reset load_ready", 32'(load_ready), 32'd0);
    checkOutput("abort reset busy", 32'(busy), 32'd1);
    lastInstr = '0;
    tick();
    rst_n = 1'b1;
    waitClear("abort reclear", 1'b0, 1'b0, '0);
    checkOutput("abort no reload", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_data  = 13'h1234;
    tick();
    load_valid = 1'b0;
    checkOutput("abort valid in run ignored", 32'(load_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      fetchCheck("abort read nop", AW'(i), 13'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
